// File: rtl/sha3_apb_fifo.sv
// sha3_apb_fifo
//   APB slave front end for a SHA3 core register space. Legal writes are
//   posted into a small FIFO and completed on the APB side at once. A drain
//   FSM replays them to the core one at a time. Reads are forwarded to the
//   core only after every earlier write has drained, so reads observe
//   program order.
//
//   Optional build macro: SHA3_APB_TIMEOUT_EN
//     When defined, a core access that stalls for TIMEOUT_CYC cycles is
//     aborted. A stalled write is dropped and wr_timeout is set (sticky). A
//     stalled read returns PSLVERR=1 with PRDATA=0. When undefined, the FSM
//     waits indefinitely for core_ready and wr_timeout is tied to 0.
//
// Ports
//   PCLK, PRESETn      clock (rising edge), asynchronous active-low reset
//   PSEL/PENABLE/PWRITE, PADDR, PWDATA         APB request
//   PRDATA, PREADY, PSLVERR                    APB response
//   core_cs, core_we, core_addr, core_wdata    core request (registered)
//   core_rdata, core_ready                     core response
//   fifo_level          posted-write FIFO occupancy
//   wr_timeout          sticky flag: a posted write was dropped on stall
//   state_dbg           current drain FSM state (0 IDLE, 1 WR, 2 RD, 3 RD_RESP)
//
// Handshake: an APB transfer completes in the access cycle
// (PSEL & PENABLE) where PREADY=1. A core transfer completes on the rising
// edge where core_cs=1 and core_ready=1. core_cs/core_we/core_addr/core_wdata
// stay constant until that edge.
module sha3_apb_fifo #(
   parameter int ADDR_W      = 10,
   parameter int FIFO_DEPTH  = 4,
   parameter int ADDR_LIMIT  = 'h200,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic                             PCLK,
   input  logic                             PRESETn,
   input  logic                             PSEL,
   input  logic                             PENABLE,
   input  logic                             PWRITE,
   input  logic [ADDR_W-1:0]                PADDR,
   input  logic [31:0]                      PWDATA,
   output logic [31:0]                      PRDATA,
   output logic                             PREADY,
   output logic                             PSLVERR,
   output logic                             core_cs,
   output logic                             core_we,
   output logic [ADDR_W-3:0]                core_addr,
   output logic [31:0]                      core_wdata,
   input  logic [31:0]                      core_rdata,
   input  logic                             core_ready,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level,
   output logic                             wr_timeout,
   output logic [1:0]                       state_dbg
);

   localparam int LVL_W = $clog2(FIFO_DEPTH+1);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int WA_W  = ADDR_W - 2;
   localparam logic [31:0] LIMIT32 = 32'(ADDR_LIMIT);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WR      = 2'd1,
      S_RD      = 2'd2,
      S_RD_RESP = 2'd3
   } state_t;

   state_t state;

   // ------------------------------------------------------------------
   // APB decode
   // ------------------------------------------------------------------
   logic        access;
   logic        legal;
   logic        illegal_acc;
   logic        rd_req;
   logic        push;
   logic        pop;
   logic        to_hit;
   logic        resp_err;
   logic [31:0] paddr_ext;

   assign paddr_ext   = 32'(PADDR);
   assign access      = PSEL && PENABLE;
   assign legal       = (PADDR[1:0] == 2'b00) && (paddr_ext < LIMIT32);
   assign illegal_acc = access && !legal;
   assign rd_req      = access && !PWRITE && legal;

   // FIFO bookkeeping
   logic [WA_W-1:0]  mem_addr [FIFO_DEPTH];
   logic [31:0]      mem_data [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [LVL_W-1:0] count;
   logic             fifo_full;
   logic             fifo_empty;

   assign fifo_full  = (count == LVL_W'(FIFO_DEPTH));
   assign fifo_empty = (count == '0);

   // A pop in the same cycle frees the slot a blocked write is waiting for,
   // so the write may complete in that very cycle.
   assign pop  = (state == S_WR) && (core_ready || to_hit);
   assign push = access && PWRITE && legal && (!fifo_full || pop);

   // Responses are combinational so that they land in the first access
   // cycle. They are forced low while reset is asserted.
   assign PREADY  = PRESETn && (illegal_acc || push || (state == S_RD_RESP));
   assign PSLVERR = PRESETn && (illegal_acc || ((state == S_RD_RESP) && resp_err));

   assign fifo_level = count;
   assign state_dbg  = state;

   always_ff @(posedge PCLK) begin
      if (push) begin
         mem_addr[wr_ptr] <= PADDR[ADDR_W-1:2];
         mem_data[wr_ptr] <= PWDATA;
      end
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + LVL_W'(1);
            2'b01:   count <= count - LVL_W'(1);
            default: count <= count;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Stall timeout
   // ------------------------------------------------------------------
`ifdef SHA3_APB_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYC+1);
   logic [TO_W-1:0] to_cnt;
   logic            in_core;
   logic            wr_to_q;

   assign in_core    = (state == S_WR) || (state == S_RD);
   // Fires on the TIMEOUT_CYC-th consecutive stalled cycle.
   assign to_hit     = in_core && !core_ready && (to_cnt == TO_W'(TIMEOUT_CYC-1));
   assign wr_timeout = wr_to_q;

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         to_cnt  <= '0;
         wr_to_q <= 1'b0;
      end else begin
         if (in_core && !core_ready && !to_hit) to_cnt <= to_cnt + TO_W'(1);
         else                                   to_cnt <= '0;
         if ((state == S_WR) && to_hit) wr_to_q <= 1'b1;
      end
   end
`else
   assign to_hit     = 1'b0;
   assign wr_timeout = 1'b0;
`endif

   // ------------------------------------------------------------------
   // Drain FSM: writes take priority, reads start only on an empty FIFO
   // ------------------------------------------------------------------
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state      <= S_IDLE;
         core_cs    <= 1'b0;
         core_we    <= 1'b0;
         core_addr  <= '0;
         core_wdata <= '0;
         PRDATA     <= '0;
         resp_err   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (!fifo_empty) begin
                  state      <= S_WR;
                  core_cs    <= 1'b1;
                  core_we    <= 1'b1;
                  core_addr  <= mem_addr[rd_ptr];
                  core_wdata <= mem_data[rd_ptr];
               end else if (rd_req) begin
                  state     <= S_RD;
                  core_cs   <= 1'b1;
                  core_we   <= 1'b0;
                  core_addr <= PADDR[ADDR_W-1:2];
               end
            end
            S_WR: begin
               if (core_ready || to_hit) begin
                  state   <= S_IDLE;
                  core_cs <= 1'b0;
                  core_we <= 1'b0;
               end
            end
            S_RD: begin
               if (core_ready) begin
                  state    <= S_RD_RESP;
                  core_cs  <= 1'b0;
                  PRDATA   <= core_rdata;
                  resp_err <= 1'b0;
               end else if (to_hit) begin
                  state    <= S_RD_RESP;
                  core_cs  <= 1'b0;
                  PRDATA   <= '0;
                  resp_err <= 1'b1;
               end
            end
            S_RD_RESP: begin
               state    <= S_IDLE;
               resp_err <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sha3_apb_fifo.sv
// tb_sha3_apb_fifo
//   Directed bench for sha3_apb_fifo. A small core model stores writes and
//   echoes them on reads. Every completed core transfer is logged, and the
//   log is compared against an expected queue of {we, word addr, wdata}.
//   The stall-timeout scenario is built only when SHA3_APB_TIMEOUT_EN is
//   defined.
module tb_sha3_apb_fifo;

   localparam int ADDR_W = 10;

   logic        PCLK = 1'b0;
   logic        PRESETn = 1'b0;
   logic        PSEL = 1'b0;
   logic        PENABLE = 1'b0;
   logic        PWRITE = 1'b0;
   logic [9:0]  PADDR = '0;
   logic [31:0] PWDATA = '0;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        PSLVERR;
   logic        core_cs;
   logic        core_we;
   logic [7:0]  core_addr;
   logic [31:0] core_wdata;
   logic [31:0] core_rdata;
   logic        core_ready = 1'b0;
   logic [2:0]  fifo_level;
   logic        wr_timeout;
   logic [1:0]  state_dbg;

   int checks = 0;
   int errors = 0;

   logic [40:0] exp_q[$];
   logic [40:0] got_q[$];
   logic [31:0] core_mem [0:255];

   sha3_apb_fifo #(
      .ADDR_W(ADDR_W), .FIFO_DEPTH(4), .ADDR_LIMIT('h200), .TIMEOUT_CYC(16)
   ) dut (
      .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
      .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
      .PREADY(PREADY), .PSLVERR(PSLVERR), .core_cs(core_cs),
      .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
      .core_rdata(core_rdata), .core_ready(core_ready),
      .fifo_level(fifo_level), .wr_timeout(wr_timeout), .state_dbg(state_dbg)
   );

   // ---------------- clock / reset ----------------
   always #5 PCLK = ~PCLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1);
   end

   // ---------------- core model and transfer log ----------------
   assign core_rdata = core_mem[core_addr];

   always @(posedge PCLK) begin
      if (PRESETn && core_cs && core_ready) begin
         got_q.push_back({core_we, core_addr, core_we ? core_wdata : 32'h0});
         if (core_we) core_mem[core_addr] <= core_wdata;
      end
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_log(input string tag);
      int n;
      check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) check(tag, 64'(got_q[i]), 64'(exp_q[i]));
      got_q.delete();
      exp_q.delete();
   endtask

   // ---------------- APB driver ----------------
   task automatic apb_xfer(input logic wr, input logic [9:0] addr, input logic [31:0] data,
                           output int waited, output logic rdy, output logic err,
                           output logic [31:0] rdata);
      @(posedge PCLK); #1;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = data;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      #1;
      waited = 0;
      while (!PREADY && waited < 40) begin
         @(posedge PCLK); #2;
         waited++;
      end
      rdy = PREADY; err = PSLVERR; rdata = PRDATA;
      @(posedge PCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0;
   endtask

   task automatic wait_drained(input string tag);
      int n = 0;
      while ((fifo_level != 0 || core_cs) && n < 60) begin
         @(posedge PCLK); #2;
         n++;
      end
      check(tag, 64'(fifo_level), 64'd0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int          waited;
      logic        rdy, err;
      logic [31:0] rdata;

      // Reset state
      repeat (3) @(posedge PCLK);
      #2;
      check("rst_pready", 64'(PREADY), 64'd0);
      check("rst_pslverr", 64'(PSLVERR), 64'd0);
      check("rst_core_cs", 64'(core_cs), 64'd0);
      check("rst_level", 64'(fifo_level), 64'd0);
      check("rst_prdata", 64'(PRDATA), 64'd0);
      check("rst_wr_timeout", 64'(wr_timeout), 64'd0);
      check("rst_state", 64'(state_dbg), 64'd0);
      @(negedge PCLK);
      PRESETn = 1'b1;

      // Four posted writes with a stalled core, then a fifth on a full FIFO
      core_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         apb_xfer(1'b1, 10'(i*4), 32'(i+1)*32'h11, waited, rdy, err, rdata);
         check("post_wr_wait", 64'(waited), 64'd0);
         check("post_wr_err", 64'(err), 64'd0);
      end
      #1;
      check("full_level", 64'(fifo_level), 64'd4);
      check("stall_cs", 64'(core_cs), 64'd1);
      check("stall_we", 64'(core_we), 64'd1);
      check("stall_addr", 64'(core_addr), 64'd0);
      check("stall_wdata", 64'(core_wdata), 64'h11);

      @(posedge PCLK); #1;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 10'h010; PWDATA = 32'h55;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      #1;
      check("full_wait0", 64'(PREADY), 64'd0);
      for (int i = 0; i < 2; i++) begin
         @(posedge PCLK); #2;
         check("full_wait", 64'(PREADY), 64'd0);
      end
      core_ready = 1'b1;
      #1;
      check("full_pop_ready", 64'(PREADY), 64'd1);
      @(posedge PCLK); #1;
      core_ready = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
      #1;
      check("push_pop_level", 64'(fifo_level), 64'd4);

      core_ready = 1'b1;
      wait_drained("drain1");
      for (int i = 0; i < 5; i++) exp_q.push_back({1'b1, 8'(i), 32'(i+1)*32'h11});
      check_log("log1");

      // Write followed by a read of the same address
      apb_xfer(1'b1, 10'h040, 32'hA5A5A5A5, waited, rdy, err, rdata);
      check("wr40_wait", 64'(waited), 64'd0);
      apb_xfer(1'b0, 10'h040, 32'h0, waited, rdy, err, rdata);
      check("rd40_wait", 64'(waited), 64'd2);
      check("rd40_err", 64'(err), 64'd0);
      check("rd40_data", 64'(rdata), 64'hA5A5A5A5);
      exp_q.push_back({1'b1, 8'h10, 32'hA5A5A5A5});
      exp_q.push_back({1'b0, 8'h10, 32'h0});
      check_log("log2");

      // Illegal addresses: misaligned, at the limit, misaligned write
      apb_xfer(1'b0, 10'h202, 32'h0, waited, rdy, err, rdata);
      check("ill202_wait", 64'(waited), 64'd0);
      check("ill202_err", 64'(err), 64'd1);
      check("ill202_prdata", 64'(rdata), 64'hA5A5A5A5);
      apb_xfer(1'b0, 10'h200, 32'h0, waited, rdy, err, rdata);
      check("ill200_wait", 64'(waited), 64'd0);
      check("ill200_err", 64'(err), 64'd1);
      apb_xfer(1'b1, 10'h013, 32'hDEAD, waited, rdy, err, rdata);
      check("ill013_err", 64'(err), 64'd1);
      check("ill013_level", 64'(fifo_level), 64'd0);
      check("ill_core_cs", 64'(core_cs), 64'd0);
      check_log("log3");

      // Highest legal address
      apb_xfer(1'b0, 10'h1FC, 32'h0, waited, rdy, err, rdata);
      check("rd1fc_wait", 64'(waited), 64'd2);
      check("rd1fc_err", 64'(err), 64'd0);
      exp_q.push_back({1'b0, 8'h7F, 32'h0});
      check_log("log4");

      // Reset in the middle of a stalled write with three entries queued
      core_ready = 1'b0;
      for (int i = 0; i < 3; i++)
         apb_xfer(1'b1, 10'h020 + 10'(i*4), 32'h100 + 32'(i), waited, rdy, err, rdata);
      #1;
      check("pre_rst_level", 64'(fifo_level), 64'd3);
      check("pre_rst_cs", 64'(core_cs), 64'd1);
      @(posedge PCLK); #3;
      PRESETn = 1'b0;
      #1;
      check("mid_rst_cs", 64'(core_cs), 64'd0);
      check("mid_rst_level", 64'(fifo_level), 64'd0);
      check("mid_rst_state", 64'(state_dbg), 64'd0);
      #1;
      PRESETn = 1'b1;
      core_ready = 1'b1;
      apb_xfer(1'b1, 10'h030, 32'h77, waited, rdy, err, rdata);
      check("post_rst_wait", 64'(waited), 64'd0);
      wait_drained("drain2");
      exp_q.push_back({1'b1, 8'h0C, 32'h77});
      check_log("log5");

`ifdef SHA3_APB_TIMEOUT_EN
      // Stall timeout on a read, then on a posted write
      core_ready = 1'b0;
      apb_xfer(1'b0, 10'h010, 32'h0, waited, rdy, err, rdata);
      check("to_rd_wait", 64'(waited), 64'd17);
      check("to_rd_err", 64'(err), 64'd1);
      check("to_rd_data", 64'(rdata), 64'd0);
      check("to_rd_flag", 64'(wr_timeout), 64'd0);
      apb_xfer(1'b1, 10'h014, 32'h99, waited, rdy, err, rdata);
      check("to_wr_wait", 64'(waited), 64'd0);
      wait_drained("to_wr_drain");
      check("to_wr_flag", 64'(wr_timeout), 64'd1);
      check_log("log6");
      core_ready = 1'b1;
`endif

      repeat (2) @(posedge PCLK);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sha3_apb_fifo.md
SHA3_APB_FIFO -- requirements
Module: sha3_apb_fifo

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, APB byte-address width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, posted-write buffer entries (power of 2, >=2).
REQ-003 SHALL have parameter ADDR_LIMIT, default 'h200, first illegal byte address.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 64, core-stall cycles before abort.
REQ-005 SHALL use one clock and an asynchronous active-low reset.
REQ-006 SHALL have port PCLK  in  1  clock, all logic rising-edge.
REQ-007 SHALL have port PRESETn  in  1  asynchronous active-low reset.
REQ-008 SHALL have ports PSEL, PENABLE, PWRITE  in  1 each  APB control.
REQ-009 SHALL have ports PADDR  in  ADDR_W and PWDATA  in  32  APB address/write data.
REQ-010 SHALL have ports PRDATA  out  32, PREADY  out  1 and PSLVERR  out  1  APB response.
REQ-011 SHALL have ports core_cs, core_we  out  1 each  core request strobe and direction.
REQ-012 SHALL have ports core_addr  out  ADDR_W-2  word address, and core_wdata  out  32.
REQ-013 SHALL have ports core_rdata  in  32 and core_ready  in  1  core response.
REQ-014 SHALL have ports fifo_level  out  $clog2(FIFO_DEPTH+1)  occupancy, and wr_timeout  out  1  sticky dropped-write flag.

Function
REQ-015 SHALL treat PSEL&!PENABLE as setup and PSEL&PENABLE as access; transfer completes in the access cycle with PREADY=1.
REQ-016 SHALL flag PADDR[1:0]!=0 or PADDR>=ADDR_LIMIT as illegal: PREADY=1, PSLVERR=1 in first access cycle; no push, no core access; PRDATA unchanged.
REQ-017 SHALL complete a legal write with PREADY=1 in its first access cycle when FIFO not full, pushing {PADDR[ADDR_W-1:2],PWDATA} exactly once.
REQ-018 SHALL hold PREADY=0 on a write while FIFO full; push and PREADY=1 in first cycle a pop frees an entry.
REQ-019 SHALL keep fifo_level unchanged on a simultaneous push and pop.
REQ-020 SHALL run drain FSM states IDLE, WR, RD, RD_RESP; IDLE->WR when FIFO non-empty (priority over reads).
REQ-021 SHALL in WR drive core_cs=1, core_we=1, core_addr/core_wdata from FIFO head, stable until core_ready=1; then pop and go to IDLE.
REQ-022 SHALL enter RD from IDLE only when FIFO empty and a legal read is in access phase, so reads follow all earlier writes.
REQ-023 SHALL in RD drive core_cs=1, core_we=0, core_addr held; on core_ready=1 register core_rdata into PRDATA and go to RD_RESP.
REQ-024 SHALL in RD_RESP assert PREADY=1, PSLVERR=0 for one cycle, then go to IDLE; read latency = core wait + 2 cycles after FIFO empty.
REQ-025 SHALL sample core_ready only while core_cs=1; core_cs=0 in IDLE and RD_RESP.
REQ-026 SHALL hold PREADY=0 and PSLVERR=0 outside the cases above.

Reset
REQ-027 SHALL on PRESETn=0 immediately: FSM=IDLE, FIFO empty, fifo_level=0, PRDATA=0, PREADY=0, PSLVERR=0, core_cs=0, core_we=0, core_addr=0, core_wdata=0, wr_timeout=0, timeout counter=0.
REQ-028 SHALL discard buffered writes and any in-flight core access on reset mid-operation.

Configuration
REQ-029 SHALL compile stall-timeout logic only when macro SHA3_APB_TIMEOUT_EN is defined.
REQ-030 SHALL with SHA3_APB_TIMEOUT_EN: count consecutive WR/RD cycles with core_ready=0; on reaching TIMEOUT_CYC, WR pops entry, sets wr_timeout, goes IDLE; RD goes RD_RESP with PSLVERR=1, PRDATA=0; counter clears on state exit.
REQ-031 SHALL without SHA3_APB_TIMEOUT_EN: wait indefinitely for core_ready; wr_timeout tied 0.

Verification
REQ-032 SHALL cover: 4 writes to 'h000-'h00C, core_ready=0 -> each PREADY=1 first access cycle, fifo_level=4; 5th write PREADY=0 until core_ready pulse.
REQ-033 SHALL cover: write 'h040=0xA5A5A5A5 then read 'h040, core echoes -> core sees write before read, PRDATA=0xA5A5A5A5, PSLVERR=0.
REQ-034 SHALL cover: read PADDR='h202 and 'h200 -> PREADY=1, PSLVERR=1 first access cycle, core_cs stays 0.
REQ-035 SHALL cover: SHA3_APB_TIMEOUT_EN, TIMEOUT_CYC=16, core_ready stuck 0, read 'h010 -> PSLVERR=1, PRDATA=0 in 17th cycle after RD entry; a write stall -> wr_timeout=1.
REQ-036 SHALL cover: PRESETn low during WR with fifo_level=3 -> core_cs=0, fifo_level=0 without clock edge; next write issues normally.
